// File: rtl/fifo_reader_if.sv
// Bundle of FIFO read-port and output-stream signals for fifo_reader.
// xfer_cnt and CNT_WIDTH exist only when FIFO_READER_CNT_EN is defined.
interface fifo_reader_if #(
  parameter int DATA_WIDTH = 8
`ifdef FIFO_READER_CNT_EN
  , parameter int CNT_WIDTH = 16
`endif
);
  logic                  enable;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  busy;
`ifdef FIFO_READER_CNT_EN
  logic [CNT_WIDTH-1:0]  xfer_cnt;
`endif

  modport master (
    input  enable, fifo_empty, fifo_data, m_ready,
`ifdef FIFO_READER_CNT_EN
    output xfer_cnt,
`endif
    output fifo_rd_en, m_valid, m_data, busy
  );

  modport slave (
    output enable, fifo_empty, fifo_data, m_ready,
`ifdef FIFO_READER_CNT_EN
    input  xfer_cnt,
`endif
    input  fifo_rd_en, m_valid, m_data, busy
  );
endinterface

// File: rtl/fifo_reader.sv
// Read-side master: pops a 1-cycle-latency FIFO into a 2-entry valid/ready buffer.
// Optional accepted-word counter enabled by defining FIFO_READER_CNT_EN.
module fifo_reader #(
  parameter int DATA_WIDTH = 8
`ifdef FIFO_READER_CNT_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic          clk,
  input  logic          rst,
  fifo_reader_if.master bus
);
  logic                  r_inflight;
  logic [1:0]            r_buf_cnt;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;

  logic                  w_valid;
  logic                  w_pop;
  logic [2:0]            w_level;
  logic                  w_rd_en;
  logic                  w_cap_head;

  assign w_valid = (r_buf_cnt != 2'd0);
  assign w_pop   = w_valid & bus.m_ready;

  // Occupancy after this edge; pop implies buf_cnt >= 1, so no underflow.
  assign w_level = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_en = !rst & bus.enable & !bus.fifo_empty & (w_level < 3'd2);

  // Incoming word lands at the head when the head slot is free after this edge.
  assign w_cap_head = (r_buf_cnt == 2'd0) || ((r_buf_cnt == 2'd1) && w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_buf_cnt  <= 2'd0;
      r_buf0     <= '0;
      r_buf1     <= '0;
    end else begin
      r_inflight <= w_rd_en;
      r_buf_cnt  <= w_level[1:0];
      if (w_pop) begin
        r_buf0 <= r_buf1;
      end
      if (r_inflight) begin
        if (w_cap_head) begin
          r_buf0 <= bus.fifo_data;
        end else begin
          r_buf1 <= bus.fifo_data;
        end
      end
    end
  end

`ifdef FIFO_READER_CNT_EN
  logic [CNT_WIDTH-1:0] r_xfer_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer_cnt <= '0;
    end else if (w_pop) begin
      r_xfer_cnt <= r_xfer_cnt + 1'b1;
    end
  end

  assign bus.xfer_cnt = r_xfer_cnt;
`endif

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.m_valid    = w_valid;
  assign bus.m_data     = r_buf0;
  assign bus.busy       = r_inflight | w_valid;
endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: FIFO model feeds the DUT, expected words
// are queued at FIFO-write time and a negedge monitor checks every pop.
module tb_fifo_reader;
  localparam int DW = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_reader_if #(
    .DATA_WIDTH(DW)
`ifdef FIFO_READER_CNT_EN
    , .CNT_WIDTH(CW)
`endif
  ) ifc ();

  fifo_reader #(
    .DATA_WIDTH(DW)
`ifdef FIFO_READER_CNT_EN
    , .CNT_WIDTH(CW)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  // Behavioural FIFO: registered read data, one-cycle latency.
  logic [DW-1:0] fifo_mem [0:2047];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign ifc.fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (ifc.fifo_rd_en) begin
      ifc.fifo_data <= fifo_mem[rd_ptr];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  logic [DW-1:0] exp_q [$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    fifo_mem[wr_ptr] = d;
    wr_ptr++;
    exp_q.push_back(d);
  endtask

  // After a reset edge, only words still inside the FIFO can ever appear.
  task automatic resync();
    exp_q.delete();
    for (int i = rd_ptr; i < wr_ptr; i++) exp_q.push_back(fifo_mem[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every accepted word.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  int            pop_cnt    = 0;
  initial begin
    forever begin
      @(negedge clk);
      assert (dut.r_buf_cnt <= 2'd2)
      else begin
        failures++;
        $display("FAIL buf_cnt_overflow actual=%0d required<=2", dut.r_buf_cnt);
      end
      if (!rst) begin
        check("rd_en_while_empty", int'(ifc.fifo_rd_en & ifc.fifo_empty), 0);
`ifdef FIFO_READER_CNT_EN
        check("xfer_cnt_track", int'(ifc.xfer_cnt), pop_cnt % (1 << CW));
`endif
        if (prev_stall && ifc.m_valid) check("hold_data", int'(ifc.m_data), int'(prev_data));
        if (ifc.m_valid && ifc.m_ready) begin
          if (exp_q.size() == 0) check("unexpected_word", int'(ifc.m_data), -1);
          else check("word_order", int'(ifc.m_data), int'(exp_q.pop_front()));
          pop_cnt++;
        end
        prev_stall = ifc.m_valid && !ifc.m_ready;
        prev_data  = ifc.m_data;
      end else begin
        prev_stall = 1'b0;
        pop_cnt    = 0;
      end
    end
  end

  initial begin
    logic [5:0] vpat;
    int r0;
    int vcnt;
    ifc.enable  = 1'b0;
    ifc.m_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();

    // Reset state, then first-word latency.
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    ifc.enable = 1'b1; ifc.m_ready = 1'b1;
    @(negedge clk);
    check("rst_m_valid", int'(ifc.m_valid), 0);
    check("rst_m_data", int'(ifc.m_data), 0);
    check("rst_busy", int'(ifc.busy), 0);
    check("rst_rd_en", int'(ifc.fifo_rd_en), 0);
    tick();
    rst = 1'b0;
    vpat = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      vpat[k] = ifc.m_valid;
    end
    check("first_valid_pattern", int'(vpat), 'h1C);
    check("idle_busy", int'(ifc.busy), 0);

    // Backpressure: only two reads until m_ready returns.
    tick();
    ifc.m_ready = 1'b0;
    r0 = rd_ptr;
    for (int i = 0; i < 8; i++) push_word(8'(i));
    repeat (6) tick();
    @(negedge clk);
    check("bp_reads", rd_ptr - r0, 2);
    check("bp_valid", int'(ifc.m_valid), 1);
    check("bp_data", int'(ifc.m_data), 0);
    tick();
    ifc.m_ready = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      vcnt += int'(ifc.m_valid);
    end
    check("bp_gapless", vcnt, 8);
    @(negedge clk);
    check("bp_done_valid", int'(ifc.m_valid), 0);
    check("bp_done_busy", int'(ifc.busy), 0);

    // Toggling m_ready.
    tick();
    for (int i = 0; i < 6; i++) push_word(8'hA0 + 8'(i));
    for (int c = 0; c < 20; c++) begin
      ifc.m_ready = ((c % 2) == 0);
      tick();
    end
    ifc.m_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("toggle_drained", exp_q.size(), 0);

    // enable dropped right after a read is issued.
    tick();
    r0 = rd_ptr;
    push_word(8'hC0); push_word(8'hC1); push_word(8'hC2);
    @(negedge clk);
    check("en_issue", int'(ifc.fifo_rd_en), 1);
    tick();
    ifc.enable = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    check("en_reads", rd_ptr - r0, 1);
    check("en_busy", int'(ifc.busy), 0);
    check("en_remaining", exp_q.size(), 2);
    ifc.enable = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    check("en_drained", exp_q.size(), 0);

    // Reset while a word is buffered and another is in flight.
    tick();
    ifc.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'hD0 + 8'(i));
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("pre_rst_valid", int'(ifc.m_valid), 1);
    check("pre_rst_busy", int'(ifc.busy), 1);
    tick();
    resync();
    @(negedge clk);
    check("midrst_valid", int'(ifc.m_valid), 0);
    check("midrst_busy", int'(ifc.busy), 0);
    check("midrst_data", int'(ifc.m_data), 0);
    check("midrst_rd_en", int'(ifc.fifo_rd_en), 0);
    tick();
    rst = 1'b0;
    ifc.m_ready = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    check("post_rst_drained", exp_q.size(), 0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      tick();
      if ($urandom_range(0, 2) == 0 && (wr_ptr - rd_ptr) < 8) push_word(8'($urandom));
      ifc.enable  = ($urandom_range(0, 7) != 0);
      ifc.m_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        tick();
        resync();
        rst = 1'b0;
      end
    end
    ifc.enable  = 1'b1;
    ifc.m_ready = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    check("random_drained", exp_q.size(), 0);
    check("random_busy", int'(ifc.busy), 0);

`ifdef FIFO_READER_CNT_EN
    tick();
    rst = 1'b1;
    tick();
    resync();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) push_word(8'h40 + 8'(i));
    repeat (25) tick();
    @(negedge clk);
    check("cnt_wrap", int'(ifc.xfer_cnt), 1);
    tick();
    rst = 1'b1;
    tick();
    resync();
    @(negedge clk);
    check("cnt_reset", int'(ifc.xfer_cnt), 0);
    tick();
    rst = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
